// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered, the result is captured and held until acked.
module alu_arbiter #(
    parameter int DATA_W  = 32,
    parameter int OPSEL_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [OPSEL_W-1:0] req0_opsel,
    input  logic               req0_iscmp,
    input  logic               req0_isjal,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [DATA_W-1:0]  req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [OPSEL_W-1:0] req1_opsel,
    input  logic               req1_iscmp,
    input  logic               req1_isjal,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [DATA_W-1:0]  req1_b,
    output logic               rsp0_valid,
    input  logic               rsp0_ack,
    output logic               rsp1_valid,
    input  logic               rsp1_ack,
    output logic [DATA_W-1:0]  rsp_data,
    output logic [OPSEL_W-1:0] alu_opsel,
    output logic               alu_iscmp,
    output logic               alu_isjal,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                prio;
    logic                gnt;
    logic                sel;
    logic                accept;
    logic                ack_gnt;
    logic [OPSEL_W-1:0]  op_opsel;
    logic                op_iscmp;
    logic                op_isjal;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [DATA_W-1:0]   res;

    // A lone valid wins outright; prio only breaks ties.
    assign sel = (req0_valid && req1_valid) ? prio : req1_valid;
    assign ack_gnt = gnt ? rsp1_ack : rsp0_ack;

    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        unique case (state_q)
            IDLE: begin
                req0_ready = req0_valid && !sel;
                req1_ready = req1_valid && sel;
                accept     = req0_valid || req1_valid;
                if (accept) state_d = EXEC;
            end
            EXEC: state_d = RESP;
            RESP: if (ack_gnt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            prio     <= 1'b0;
            gnt      <= 1'b0;
            op_opsel <= '0;
            op_iscmp <= 1'b0;
            op_isjal <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            res      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                gnt      <= sel;
                op_opsel <= sel ? req1_opsel : req0_opsel;
                op_iscmp <= sel ? req1_iscmp : req0_iscmp;
                op_isjal <= sel ? req1_isjal : req0_isjal;
                op_a     <= sel ? req1_a : req0_a;
                op_b     <= sel ? req1_b : req0_b;
            end
            if (state_q == EXEC) res <= alu_out;
            if (state_q == RESP && ack_gnt) prio <= ~gnt;
        end
    end

    assign rsp0_valid = (state_q == RESP) && !gnt;
    assign rsp1_valid = (state_q == RESP) && gnt;
    assign rsp_data   = res;
    assign alu_opsel  = op_opsel;
    assign alu_iscmp  = op_iscmp;
    assign alu_isjal  = op_isjal;
    assign alu_a      = op_a;
    assign alu_b      = op_b;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle combinational ALU between two requesters, for example the main pipeline execute stage and a secondary unit such as branch or address generation. The arbiter accepts one operation at a time through a valid/ready handshake and uses round-robin arbitration. It registers the operands into the ALU, captures the ALU result, and returns it to the winning requester through a held valid/ack response. It sits between the requesters and the ALU instance and is the only driver of the ALU inputs.

## Interface
Parameters:
- DATA_W, 32, operand and result width
- OPSEL_W, 6, width of the ALU operation select

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- req0_valid / req1_valid  in  1  requester n presents an operation
- req0_ready / req1_ready  out  1  arbiter accepts requester n this cycle
- reqN_opsel  in  OPSEL_W  operation select for requester n
- reqN_iscmp  in  1  compare flag for requester n
- reqN_isjal  in  1  jump-and-link flag for requester n
- reqN_a  in  DATA_W  operand A for requester n
- reqN_b  in  DATA_W  operand B for requester n
- rsp0_valid / rsp1_valid  out  1  result available for requester n
- rsp0_ack / rsp1_ack  in  1  requester n consumes the result
- rsp_data  out  DATA_W  result, shared by both requesters, qualified by rspN_valid
- alu_opsel  out  OPSEL_W  drives ALU opsel
- alu_iscmp  out  1  drives ALU isCMP
- alu_isjal  out  1  drives ALU isJAL
- alu_a  out  DATA_W  drives ALU A
- alu_b  out  DATA_W  drives ALU B
- alu_out  in  DATA_W  ALU result (combinational)

## Operation
- State machine with states IDLE, EXEC and RESP, plus a 1-bit priority pointer `prio` and a 1-bit grant register `gnt`.
- IDLE:
  - reqN_ready is high only for the selected requester n. Ready is combinational from valid, state and prio.
  - Selection when both valids are high: requester `prio` wins.
  - Selection when one valid is high: that requester wins, regardless of prio.
  - On the handshake (valid & ready):
    - opsel, iscmp, isjal, a and b latch into the operand registers;
    - gnt is set to the winner;
    - the state moves to EXEC.
  - With no valid, the state stays IDLE.
- EXEC:
  - The ALU inputs come from the operand registers, as they do in every state.
  - alu_out is captured into rsp_data.
  - The state moves to RESP.
  - Both readies are low.
- RESP:
  - rsp[gnt]_valid is high. The other rsp valid is low.
  - rsp_data is held.
  - On rsp[gnt]_ack the arbiter:
    - clears valid;
    - sets prio to ~gnt;
    - moves to IDLE.
  - Ack on the non-granted port is ignored.
  - Both readies are low.
- The operand registers hold their value outside the handshake cycle, so the ALU inputs are stable for the whole of EXEC.
- No arithmetic is done in the arbiter. rsp_data equals the ALU output bit-for-bit.
- The requester protocol is that valid and the request fields stay stable until ready. The arbiter does not check this.

## Timing
- Reset (rst_n low at a rising edge):
  - state = IDLE, prio = 0, gnt = 0;
  - rsp0_valid = rsp1_valid = 0;
  - rsp_data = 0;
  - operand registers = 0, so alu_opsel, alu_iscmp, alu_isjal, alu_a and alu_b are all 0.
- Reset has priority over every other event. A reset in EXEC or RESP discards the in-flight operation and no response is issued.
- Latency:
  - the handshake is in cycle N;
  - the ALU is driven with the new operands from N+1;
  - rsp_data is valid and rspN_valid is high from N+2;
  - the earliest ack is at N+2, returning to IDLE at N+3.
- Minimum issue interval is 3 cycles per operation. A new request can be accepted in the first IDLE cycle after the ack.
- A response with ack held low stays valid indefinitely, with rsp_data unchanged.
- A pending request from the other requester during EXEC or RESP waits, and is served next because prio flips.
- An ack that arrives in IDLE or EXEC is ignored.

## Test plan
- Reset: assert rst_n = 0 for 2 cycles. Require all rsp valids 0, rsp_data 0, alu_a = alu_b = 0 and both readies low with no requests. Then present req0 and require req0_ready high.
- Single op: req0 issues ADD with A = 5, B = 7. Require req0_ready at N, alu_a = 5 and alu_b = 7 at N+1, and rsp0_valid with rsp_data = 12 at N+2. Hold ack low for 4 cycles and require data held at 12. Ack, and require IDLE the next cycle.
- Contention: req0 and req1 are both valid from reset. req0 carries MVHI with B = 0x1234; req1 carries SUB with 9, 4.
  - First grant is req0, returning 0x12340000.
  - Then req1, returning 5.
  - Then, with both still valid, req0 again (round-robin alternation).
- Compare and JAL: req1 issues isCMP with opsel LT, A = -1, B = 1, and must return 1. Then req1 issues isJAL with A = 0x100, B = 3, and must return 0x10C. With req0 idle, req1 wins both times even though prio = 0.
- Stray acks: pulse rsp0_ack during req1's EXEC and RESP. Require no effect: rsp1_valid stays high and the state stays RESP until rsp1_ack.
- Reset mid-operation: assert rst_n = 0 in EXEC. Require no rsp valid ever rises for that operation, rsp_data = 0, prio = 0 and the state IDLE after reset.
